// File: rtl/spi_txn_if.sv
// Request/response and SPI pin bundle for the soft SPI master.
// master = requester side, slave = the transaction controller.
interface spi_txn_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              cpol;
    logic              cpha;
    logic              MISO;
    logic              SCLK;
    logic              MOSI;
    logic              CS_N;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;

    modport master (
        output start, tx_data, cpol, cpha, MISO,
        input  SCLK, MOSI, CS_N, busy, done, rx_data
    );

    modport slave (
        input  start, tx_data, cpol, cpha, MISO,
        output SCLK, MOSI, CS_N, busy, done, rx_data
    );
endinterface

// File: rtl/spi_txn_controller.sv
// Single-byte CS_N-framed SPI exchange with CPOL/CPHA modes
// and a divided, registered SCLK.
module spi_txn_controller #(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 3,
    parameter int CS_HOLD  = 3
) (
    input logic      CLOCK_50,
    input logic      reset,
    spi_txn_if.slave bus
);
    localparam int EW = $clog2(2 * DATA_W) + 1;
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CS_MAX =
        (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int PW = (CS_MAX > 1) ? $clog2(CS_MAX) : 1;

    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);
    localparam logic [HW-1:0] HALF_END  = HW'(CLK_DIV - 1);
    localparam logic [PW-1:0] SETUP_END = PW'(CS_SETUP - 1);
    localparam logic [PW-1:0] HOLD_END  = PW'(CS_HOLD - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t            state;
    logic [PW-1:0]     ph_cnt;
    logic [HW-1:0]     half_cnt;
    logic [EW-1:0]     edge_cnt;
    logic [EW-1:0]     edge_nx;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] rx_q;
    logic              cpol_q;
    logic              cpha_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              cs_n_q;
    logic              busy_q;
    logic              done_q;
    logic              capture;

    assign edge_nx = edge_cnt + EW'(1);
    // Odd edges are leading: capture there for cpha=0, trailing for cpha=1
    assign capture = edge_nx[0] ^ cpha_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            ph_cnt   <= '0;
            half_cnt <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_q     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            sclk_q   <= 1'b1;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    sclk_q <= bus.cpol;
                    mosi_q <= 1'b0;
                    if (bus.start) begin
                        state  <= SETUP;
                        ph_cnt <= '0;
                        tx_sr  <= bus.tx_data;
                        rx_sr  <= '0;
                        cpol_q <= bus.cpol;
                        cpha_q <= bus.cpha;
                        mosi_q <= bus.cpha ? 1'b0
                                  : bus.tx_data[DATA_W-1];
                        cs_n_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                SETUP: begin
                    if (ph_cnt == SETUP_END) begin
                        state    <= XFER;
                        half_cnt <= '0;
                        edge_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + PW'(1);
                    end
                end
                XFER: begin
                    if (half_cnt != HALF_END) begin
                        half_cnt <= half_cnt + HW'(1);
                    end else begin
                        half_cnt <= '0;
                        edge_cnt <= edge_nx;
                        sclk_q   <= ~sclk_q;
                        if (capture) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], bus.MISO};
                        end else if (edge_nx != LAST_EDGE) begin
                            // cpha=0 already shows the MSB, so step one ahead
                            mosi_q <= cpha_q ? tx_sr[DATA_W-1]
                                      : tx_sr[DATA_W-2];
                            tx_sr  <= tx_sr << 1;
                        end
                        if (edge_nx == LAST_EDGE) begin
                            state  <= HOLD;
                            ph_cnt <= '0;
                        end
                    end
                end
                HOLD: begin
                    if (ph_cnt == HOLD_END) begin
                        state  <= IDLE;
                        cs_n_q <= 1'b1;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        rx_q   <= rx_sr;
                        mosi_q <= 1'b0;
                    end else begin
                        ph_cnt <= ph_cnt + PW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.SCLK    = sclk_q;
    assign bus.MOSI    = mosi_q;
    assign bus.CS_N    = cs_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
endmodule

// File: tb/tb_spi_txn_controller.sv
// Bench for spi_txn_controller: cycle-level reference model
// plus directed mode/abort/back-to-back scenarios and random traffic.
module tb_spi_txn_controller;
    localparam int W     = 8;
    localparam int CD    = 2;
    localparam int SU    = 3;
    localparam int HD    = 3;
    localparam int TOTAL = SU + 2 * W * CD + HD;

    logic clk;
    logic reset;
    logic [1:0] miso_mode;
    logic slv_load;
    logic slv_bit;
    logic [7:0] slv_sr;
    logic rnd_bit;

    int total = 0;
    int bad = 0;

    spi_txn_if #(.DATA_W(W)) bus();

    spi_txn_controller #(
        .DATA_W(W), .CLK_DIV(CD),
        .CS_SETUP(SU), .CS_HOLD(HD)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    assign bus.MISO = (miso_mode == 2'd0) ? bus.MOSI :
                      (miso_mode == 2'd1) ? 1'b1 :
                      (miso_mode == 2'd2) ? slv_bit : rnd_bit;

    // Slave device for mode 1: presents next bit on SCLK rising
    always @(posedge bus.SCLK or posedge slv_load) begin
        if (slv_load) begin
            slv_sr  <= 8'hA5;
            slv_bit <= 1'b0;
        end else begin
            slv_bit <= slv_sr[7];
            slv_sr  <= {slv_sr[6:0], 1'b0};
        end
    end

    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    logic p_reset, p_start, p_cpol, p_cpha, p_miso;
    logic [W-1:0] p_tx;
    always @(posedge clk) begin
        p_reset <= reset;
        p_start <= bus.start;
        p_cpol  <= bus.cpol;
        p_cpha  <= bus.cpha;
        p_miso  <= bus.MISO;
        p_tx    <= bus.tx_data;
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int ecnt(input int k);
        int e;
        if (k < SU) return 0;
        e = (k - SU) / CD;
        return (e > 2 * W) ? 2 * W : e;
    endfunction

    bit m_act = 1'b0;
    int m_k = 0;
    logic m_cpol = 1'b0;
    logic m_cpha = 1'b0;
    logic [W-1:0] m_tx = '0;
    logic [W-1:0] m_rx = '0;
    logic [W-1:0] m_rxout = '0;
    logic m_sclk_idle = 1'b1;
    logic m_done = 1'b0;

    // Reference model: outputs follow from cycles since acceptance
    initial begin
        int n, bi;
        logic e_sclk, e_mosi;
        logic [12:0] ev;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (p_reset) begin
                m_act = 1'b0;
                m_rxout = '0;
                m_sclk_idle = 1'b1;
            end else if (m_act) begin
                m_k++;
                n = ecnt(m_k);
                if (n != ecnt(m_k - 1) &&
                    ((n % 2 == 1) == (m_cpha == 1'b0)))
                    m_rx = {m_rx[W-2:0], p_miso};
                if (m_k == TOTAL) begin
                    m_act = 1'b0;
                    m_done = 1'b1;
                    m_rxout = m_rx;
                    m_sclk_idle = m_cpol;
                end
            end else begin
                m_sclk_idle = p_cpol;
                if (p_start) begin
                    m_act = 1'b1;
                    m_k = 0;
                    m_cpol = p_cpol;
                    m_cpha = p_cpha;
                    m_tx = p_tx;
                    m_rx = '0;
                end
            end
            if (m_act) begin
                n = ecnt(m_k);
                e_sclk = m_cpol ^ n[0];
                if (!m_cpha)
                    bi = (n / 2 > W - 1) ? W - 1 : n / 2;
                else if (n == 0)
                    bi = -1;
                else
                    bi = ((n - 1) / 2 > W - 1) ? W - 1 : (n - 1) / 2;
                e_mosi = (bi < 0) ? 1'b0 : m_tx[W-1-bi];
                ev = {1'b0, 1'b1, e_sclk, e_mosi, m_done, m_rxout};
            end else begin
                ev = {1'b1, 1'b0, m_sclk_idle, 1'b0, m_done, m_rxout};
            end
            check("cycle",
                  {bus.CS_N, bus.busy, bus.SCLK, bus.MOSI,
                   bus.done, bus.rx_data}, ev);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input logic [7:0] d,
                             input logic pol, input logic pha);
        bus.tx_data = d;
        bus.cpol = pol;
        bus.cpha = pha;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic watch(input logic chain, input logic [7:0] cd,
                         output int cs_low, output int rises,
                         output logic [7:0] mr, output int unst,
                         output int ndone, output int done_c);
        logic ps, pm;
        cs_low = 0; rises = 0; mr = '0;
        unst = 0; ndone = 0; done_c = -1;
        ps = bus.SCLK;
        pm = bus.MOSI;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!bus.CS_N) cs_low++;
            if (!ps && bus.SCLK) begin
                rises++;
                mr = {mr[6:0], pm};
            end
            if (ps && !bus.SCLK && pm != bus.MOSI) unst++;
            if (bus.done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
            ps = bus.SCLK;
            pm = bus.MOSI;
            if (done_c >= 0 && chain) begin
                bus.tx_data = cd;
                bus.start = 1'b1;
                break;
            end
            if (done_c >= 0 && c >= done_c + 3) break;
        end
    endtask

    int csl, rs, us, nd, dc;
    logic [7:0] mr;

    initial begin
        int found;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.tx_data = '0;
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
        miso_mode = 2'd0;
        slv_load = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_state",
              {bus.CS_N, bus.busy, bus.SCLK, bus.MOSI,
               bus.done, bus.rx_data},
              {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        tick();
        reset = 1'b0;
        repeat (2) tick();

        start_txn(8'hCE, 1'b0, 1'b0);
        watch(1'b0, 8'h00, csl, rs, mr, us, nd, dc);
        check("m0_rises", rs, 8);
        check("m0_cs_low", csl, 38);
        check("m0_done_lat", dc + 1, 39);
        check("m0_ndone", nd, 1);
        check("m0_rx", bus.rx_data, 8'hCE);

        miso_mode = 2'd1;
        bus.cpol = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("m3_idle_sclk", bus.SCLK, 1);
        start_txn(8'h3C, 1'b1, 1'b1);
        watch(1'b0, 8'h00, csl, rs, mr, us, nd, dc);
        check("m3_rises", rs, 8);
        check("m3_mosi", mr, 8'h3C);
        check("m3_rx", bus.rx_data, 8'hFF);

        miso_mode = 2'd2;
        bus.cpol = 1'b0;
        repeat (2) tick();
        slv_load = 1'b1;
        #1;
        slv_load = 1'b0;
        start_txn(8'h66, 1'b0, 1'b1);
        watch(1'b0, 8'h00, csl, rs, mr, us, nd, dc);
        check("m1_rx", bus.rx_data, 8'hA5);
        check("m1_mosi_stable", us, 0);
        check("m1_rises", rs, 8);

        miso_mode = 2'd0;
        start_txn(8'h5A, 1'b0, 1'b0);
        repeat (4) tick();
        bus.tx_data = 8'h00;
        bus.cpha = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        watch(1'b0, 8'h00, csl, rs, mr, us, nd, dc);
        check("busy_done_at", dc, 33);
        check("busy_ndone", nd, 1);
        check("busy_rx", bus.rx_data, 8'h5A);
        bus.cpha = 1'b0;

        start_txn(8'hCE, 1'b0, 1'b0);
        repeat (12) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_state",
              {bus.CS_N, bus.busy, bus.SCLK, bus.MOSI,
               bus.done, bus.rx_data},
              {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        nd = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check("abort_no_done", nd, 0);
        start_txn(8'h96, 1'b0, 1'b0);
        watch(1'b0, 8'h00, csl, rs, mr, us, nd, dc);
        check("abort_next_rx", bus.rx_data, 8'h96);
        check("abort_next_cs", csl, 38);

        start_txn(8'h3C, 1'b0, 1'b0);
        watch(1'b1, 8'h81, csl, rs, mr, us, nd, dc);
        check("b2b_first_done", dc, 38);
        check("b2b_gap_cs", bus.CS_N, 1);
        tick();
        bus.start = 1'b0;
        check("b2b_cs_relow", bus.CS_N, 0);
        watch(1'b0, 8'h00, csl, rs, mr, us, nd, dc);
        check("b2b_cs_low", csl, 38);
        check("b2b_rx", bus.rx_data, 8'h81);

        miso_mode = 2'd3;
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            start_txn(8'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(1, 30)) tick();
            bus.tx_data = 8'($urandom);
            bus.cpha = ~bus.cpha;
            bus.cpol = ~bus.cpol;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            found = 0;
            for (int c = 0; c < 60 && found == 0; c++) begin
                @(negedge clk);
                if (bus.done) found = 1;
            end
            check("rnd_done", found, 1);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
